// File: rtl/rd_stream_arbiter.sv
// rd_stream_arbiter
// Round-robin scheduler that shares one AXI4 read address channel among
// N_REQ stream requesters. ARID carries the requester index. The block
// tracks one outstanding burst per requester and pulses that requester's
// done output when the matching RLAST is accepted.

module rd_stream_arbiter #(
    parameter int N_REQ     = 12,
    parameter int BURST_LEN = 64,
    parameter int ADDR_W    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          done,
    output logic [N_REQ-1:0]          pending,
    output logic [4:0]                outstanding,
    output logic                      err_unexp,
    output logic [ADDR_W-1:0]         ARADDR,
    output logic [3:0]                ARID,
    output logic [7:0]                ARLEN,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    input  logic [3:0]                RID,
    input  logic                      RLAST,
    input  logic                      RVALID,
    output logic                      RREADY
);

    typedef enum logic {
        S_IDLE,
        S_ADDR
    } state_t;

    localparam logic [7:0] ARLEN_VAL = 8'(BURST_LEN - 1);
    localparam logic [4:0] N_REQ_W   = 5'(N_REQ);
    localparam logic [3:0] LAST_IDX  = 4'(N_REQ - 1);

    // Registered state
    state_t              state_q;
    logic [3:0]          rr_ptr_q;
    logic [ADDR_W-1:0]   araddr_q;
    logic [3:0]          arid_q;
    logic [7:0]          arlen_q;
    logic                arvalid_q;
    logic [N_REQ-1:0]    grant_q;
    logic [N_REQ-1:0]    pending_q, pending_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic                err_q, err_d;
    logic                rready_q;

    // Selection helpers
    logic [N_REQ-1:0]    eligible;
    logic [2*N_REQ-1:0]  elig_rot;
    logic                pick_found;
    logic [3:0]          pick_off;
    logic [4:0]          pick_sum;
    logic [3:0]          pick_idx;
    logic [N_REQ-1:0]    pick_onehot;
    logic [ADDR_W-1:0]   pick_addr;

    // Read-side helpers
    logic                ar_fire;
    logic                r_last_fire;
    logic [N_REQ-1:0]    rid_hit;
    logic [N_REQ-1:0]    arid_hit;
    logic                rid_ok;

    // Round-robin pick: rotate eligibility so bit k is requester (rr_ptr+k) mod N_REQ
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        eligible    = req & ~pending_q;
        elig_rot    = {eligible, eligible} >> rr_ptr_q;
        pick_found  = 1'b0;
        pick_off    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!pick_found && elig_rot[k]) begin
                pick_found = 1'b1;
                pick_off   = 4'(k);
            end
        end
        pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
        if (pick_sum >= N_REQ_W) begin
            pick_sum = pick_sum - N_REQ_W;
        end
        pick_idx    = pick_sum[3:0];
        pick_onehot = '0;
        pick_addr   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == 4'(i)) begin
                pick_onehot[i] = 1'b1;
                pick_addr      = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // AR scheduling FSM with registered AXI outputs and grant pulse
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            araddr_q  <= '0;
            arid_q    <= '0;
            arlen_q   <= '0;
            arvalid_q <= 1'b0;
            grant_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    grant_q <= '0;
                    if (pick_found) begin
                        araddr_q  <= pick_addr;
                        arid_q    <= pick_idx;
                        arlen_q   <= ARLEN_VAL;
                        arvalid_q <= 1'b1;
                        grant_q   <= pick_onehot;
                        state_q   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    grant_q <= '0;
                    // Address, ID and length stay frozen until the slave accepts
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        rr_ptr_q  <= (arid_q == LAST_IDX) ? 4'd0 : arid_q + 4'd1;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    arvalid_q <= 1'b0;
                    grant_q   <= '0;
                end
            endcase
        end
    end

    // Pending/done/error next state: RLAST clears first, an AR handshake set wins on the same index
    always_comb begin
        ar_fire     = arvalid_q & ARREADY;
        r_last_fire = RVALID & rready_q & RLAST;
        rid_hit     = '0;
        arid_hit    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rid_hit[i]  = (RID == 4'(i));
            arid_hit[i] = (arid_q == 4'(i));
        end
        // An RID outside 0..N_REQ-1 matches no bit and so is never "ok"
        rid_ok    = |(rid_hit & pending_q);
        pending_d = pending_q;
        done_d    = '0;
        err_d     = err_q;
        if (r_last_fire) begin
            if (rid_ok) begin
                pending_d = pending_d & ~rid_hit;
                done_d    = rid_hit;
            end else begin
                err_d = 1'b1;
            end
        end
        if (ar_fire) begin
            pending_d = pending_d | arid_hit;
        end
    end

    // Burst tracking registers and R-channel ready
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rready_q  <= 1'b1;
        end
    end

    // Population count of in-flight bursts
    always_comb begin
        outstanding = '0;
        for (int i = 0; i < N_REQ; i++) begin
            outstanding = outstanding + 5'(pending_q[i]);
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign pending   = pending_q;
    assign err_unexp = err_q;
    assign ARADDR    = araddr_q;
    assign ARID      = arid_q;
    assign ARLEN     = arlen_q;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;

endmodule

// File: tb/tb_rd_stream_arbiter.sv
// tb_rd_stream_arbiter
// Table-driven cycle vectors for the main paths, followed by hand-written
// sequences for full bursts, fairness, backpressure, pending blocking and
// reset while an AR is in flight.

module tb_rd_stream_arbiter;

    localparam int N  = 12;
    localparam int AW = 32;
    localparam int BL = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      grant, done, pending;
    logic [4:0]        outstanding;
    logic              err_unexp;
    logic [AW-1:0]     ARADDR;
    logic [3:0]        ARID;
    logic [7:0]        ARLEN;
    logic              ARVALID, ARREADY;
    logic [3:0]        RID;
    logic              RLAST, RVALID, RREADY;

    int n_checks = 0;
    int n_errors = 0;

    rd_stream_arbiter #(.N_REQ(N), .BURST_LEN(BL), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .grant(grant), .done(done), .pending(pending), .outstanding(outstanding),
        .err_unexp(err_unexp), .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [N-1:0] req;
        logic         arready;
        logic         rvalid;
        logic         rlast;
        logic [3:0]   rid;
        logic         exp_arvalid;
        logic [3:0]   exp_arid;
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_pending;
        logic [N-1:0] exp_done;
        logic         exp_err;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req     = '0;
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        RLAST   = 1'b0;
        RID     = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0010_0000;
    endfunction

    function automatic vec_t mk(input logic [N-1:0] r, input logic ar, input logic rv,
                                input logic rl, input logic [3:0] id, input logic earv,
                                input logic [3:0] eid, input logic [N-1:0] eg,
                                input logic [N-1:0] ep, input logic [N-1:0] ed, input logic ee);
        vec_t v;
        v.req = r; v.arready = ar; v.rvalid = rv; v.rlast = rl; v.rid = id;
        v.exp_arvalid = earv; v.exp_arid = eid; v.exp_grant = eg;
        v.exp_pending = ep; v.exp_done = ed; v.exp_err = ee;
        return v;
    endfunction

    vec_t vt[16];

    initial begin
        int n_grant;
        int bad;
        logic [N-1:0] one;

        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr_of(i);

        // Reset state
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        check("rst arvalid", 64'(ARVALID), 64'd0);
        check("rst araddr",  64'(ARADDR),  64'd0);
        check("rst arid",    64'(ARID),    64'd0);
        check("rst arlen",   64'(ARLEN),   64'd0);
        check("rst grant",   64'(grant),   64'd0);
        check("rst done",    64'(done),    64'd0);
        check("rst pending", 64'(pending), 64'd0);
        check("rst err",     64'(err_unexp), 64'd0);
        check("rst rready",  64'(RREADY),  64'd0);
        reset = 1'b0;
        step();
        check("rready after reset", 64'(RREADY), 64'd1);

        //          req     ar  rv  rl  rid | arv id grant   pend    done    err
        vt[0]  = mk(12'h008,1'b0,1'b0,1'b0,4'd0, 1'b1,4'd3,12'h008,12'h000,12'h000,1'b0);
        vt[1]  = mk(12'h000,1'b1,1'b0,1'b0,4'd0, 1'b0,4'd0,12'h000,12'h008,12'h000,1'b0);
        vt[2]  = mk(12'h000,1'b1,1'b1,1'b0,4'd3, 1'b0,4'd0,12'h000,12'h008,12'h000,1'b0);
        vt[3]  = mk(12'h000,1'b1,1'b1,1'b1,4'd3, 1'b0,4'd0,12'h000,12'h000,12'h008,1'b0);
        vt[4]  = mk(12'h000,1'b0,1'b0,1'b0,4'd0, 1'b0,4'd0,12'h000,12'h000,12'h000,1'b0);
        vt[5]  = mk(12'h082,1'b1,1'b0,1'b0,4'd0, 1'b1,4'd7,12'h080,12'h000,12'h000,1'b0);
        vt[6]  = mk(12'h082,1'b1,1'b0,1'b0,4'd0, 1'b0,4'd0,12'h000,12'h080,12'h000,1'b0);
        vt[7]  = mk(12'h082,1'b1,1'b0,1'b0,4'd0, 1'b1,4'd1,12'h002,12'h080,12'h000,1'b0);
        vt[8]  = mk(12'h000,1'b1,1'b1,1'b1,4'd7, 1'b0,4'd0,12'h000,12'h002,12'h080,1'b0);
        vt[9]  = mk(12'h002,1'b1,1'b1,1'b1,4'd1, 1'b0,4'd0,12'h000,12'h000,12'h002,1'b0);
        vt[10] = mk(12'h002,1'b0,1'b0,1'b0,4'd0, 1'b1,4'd1,12'h002,12'h000,12'h000,1'b0);
        vt[11] = mk(12'h000,1'b1,1'b0,1'b0,4'd0, 1'b0,4'd0,12'h000,12'h002,12'h000,1'b0);
        vt[12] = mk(12'h000,1'b0,1'b1,1'b1,4'd14,1'b0,4'd0,12'h000,12'h002,12'h000,1'b1);
        vt[13] = mk(12'h000,1'b0,1'b1,1'b1,4'd2, 1'b0,4'd0,12'h000,12'h002,12'h000,1'b1);
        vt[14] = mk(12'h000,1'b0,1'b1,1'b1,4'd1, 1'b0,4'd0,12'h000,12'h000,12'h002,1'b1);
        vt[15] = mk(12'h000,1'b0,1'b0,1'b0,4'd0, 1'b0,4'd0,12'h000,12'h000,12'h000,1'b1);

        for (int r = 0; r < 16; r++) begin
            req = vt[r].req; ARREADY = vt[r].arready;
            RVALID = vt[r].rvalid; RLAST = vt[r].rlast; RID = vt[r].rid;
            step();
            check($sformatf("row%0d arvalid", r), 64'(ARVALID), 64'(vt[r].exp_arvalid));
            check($sformatf("row%0d grant", r),   64'(grant),   64'(vt[r].exp_grant));
            check($sformatf("row%0d pending", r), 64'(pending), 64'(vt[r].exp_pending));
            check($sformatf("row%0d done", r),    64'(done),    64'(vt[r].exp_done));
            check($sformatf("row%0d err", r),     64'(err_unexp), 64'(vt[r].exp_err));
            check($sformatf("row%0d outstanding", r), 64'(outstanding),
                  64'($countones(vt[r].exp_pending)));
            if (vt[r].exp_arvalid) begin
                check($sformatf("row%0d arid", r),   64'(ARID),   64'(vt[r].exp_arid));
                check($sformatf("row%0d araddr", r), 64'(ARADDR), 64'(addr_of(int'(vt[r].exp_arid))));
                check($sformatf("row%0d arlen", r),  64'(ARLEN),  64'd63);
            end
        end

        // Full 64-beat burst for requester 3
        do_reset();
        req_addr[3*AW +: AW] = 32'h1000_0000;
        req = 12'h008; ARREADY = 1'b1;
        step();
        check("burst ar", {ARVALID, ARID, ARLEN, ARADDR}, {1'b1, 4'd3, 8'd63, 32'h1000_0000});
        req = '0;
        step();
        check("burst pending", 64'({ARVALID, pending}), 64'({1'b0, 12'h008}));
        bad = 0;
        for (int b = 0; b < BL; b++) begin
            RVALID = 1'b1; RID = 4'd3; RLAST = (b == BL - 1);
            step();
            if (b < BL - 1 && (done != '0 || pending != 12'h008)) bad++;
        end
        check("burst mid beats", 64'(bad), 64'd0);
        check("burst done", 64'({done, pending, outstanding}), 64'({12'h008, 12'h000, 5'd0}));
        RVALID = 1'b0; RLAST = 1'b0;
        step();
        check("burst done pulse", 64'(done), 64'd0);
        req_addr[3*AW +: AW] = addr_of(3);

        // Fairness: all requesters held, RLAST returned immediately
        do_reset();
        req = '1; ARREADY = 1'b1;
        n_grant = 0;
        for (int cyc = 0; cyc < 150 && n_grant < 13; cyc++) begin
            step();
            if (grant != '0) begin
                one = 12'(1) << (n_grant % N);
                check($sformatf("fair grant %0d", n_grant), 64'(grant), 64'(one));
                check($sformatf("fair arid %0d", n_grant), 64'(ARID), 64'(n_grant % N));
                n_grant++;
            end
            RVALID = 1'b0; RLAST = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (pending[i]) begin
                    RVALID = 1'b1; RLAST = 1'b1; RID = 4'(i);
                end
            end
        end
        check("fair grant count", 64'(n_grant), 64'd13);

        // Backpressure: ARREADY low for 10 cycles, address change ignored
        do_reset();
        req_addr[2*AW +: AW] = 32'hDEAD_0000;
        req = 12'h004;
        step();
        check("bp first", {ARVALID, ARID, ARADDR, grant}, {1'b1, 4'd2, 32'hDEAD_0000, 12'h004});
        req = '0;
        req_addr[2*AW +: AW] = 32'hBEEF_0000;
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("bp hold %0d", c), {3'd0, ARVALID, ARID, ARADDR, grant, pending},
                  {3'd0, 1'b1, 4'd2, 32'hDEAD_0000, 12'h000, 12'h000});
        end
        ARREADY = 1'b1;
        step();
        check("bp accept", 64'({ARVALID, pending}), 64'({1'b0, 12'h004}));
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (ARVALID || grant != '0) bad++;
        end
        check("bp no second ar", 64'(bad), 64'd0);
        req_addr[2*AW +: AW] = addr_of(2);

        // Pending block on requester 5
        do_reset();
        req = 12'h020; ARREADY = 1'b1;
        n_grant = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (grant != '0) n_grant++;
        end
        check("blk grant count", 64'(n_grant), 64'd1);
        check("blk pending", 64'(pending), 64'h020);
        RVALID = 1'b1; RLAST = 1'b1; RID = 4'd5;
        step();
        check("blk rlast", 64'({ARVALID, done, pending}), 64'({1'b0, 12'h020, 12'h000}));
        RVALID = 1'b0; RLAST = 1'b0;
        step();
        check("blk reissue", 64'({ARVALID, ARID, grant}), 64'({1'b1, 4'd5, 12'h020}));

        // Reset while an AR is in flight; pointer and pending cleared
        do_reset();
        req = 12'h200; ARREADY = 1'b1;
        step();
        step();
        check("mid pre pending", 64'(pending), 64'h200);
        req = 12'h401; ARREADY = 1'b0;
        step();
        check("mid pre ar", 64'({ARVALID, ARID}), 64'({1'b1, 4'd10}));
        reset = 1'b1;
        step();
        check("mid reset", 64'({ARVALID, pending, grant, err_unexp, outstanding}),
              64'({1'b0, 12'h000, 12'h000, 1'b0, 5'd0}));
        reset = 1'b0;
        step();
        check("mid rr ptr", 64'({ARVALID, ARID}), 64'({1'b1, 4'd0}));
        RVALID = 1'b1; RLAST = 1'b1; RID = 4'd9;
        step();
        check("mid stray rlast", 64'({err_unexp, pending}), 64'({1'b1, 12'h000}));
        idle_inputs();
        step();
        check("mid err sticky", 64'(err_unexp), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
